mem_access_unit: RTL and testbench

- Memory-stage consumer of the effective address produced by address generation.
- Takes an effective address, access size, signedness and direction.
- Checks natural alignment and drives a byte-enabled, word-wide data memory port with an ack handshake.
- Returns sign- or zero-extended load data, or an exception code, to the writeback/exception logic.

---
 rtl/mem_access_unit.sv | 231 +++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: natural-alignment check, byte-enabled word port
// with ack handshake and bus timeout, formatted load data or exception response.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_eff_addr,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_mem_en,
  output logic [3:0]        o_mem_be,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rdata,
  output logic [1:0]        o_exc
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_ALIGN   = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT = 2'b10;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  function automatic logic is_misaligned(input logic [1:0] lo, input logic [1:0] sz);
    logic m;
    case (sz)
      2'b00:   m = 1'b0;
      2'b01:   m = lo[0];
      2'b10:   m = (lo != 2'b00);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] lo, input logic [1:0] sz, input logic we);
    logic [3:0] be;
    if (!we) begin
      be = 4'b1111;
    end else begin
      case (sz)
        2'b00:   be = 4'b0001 << lo;
        2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  function automatic logic [DATA_W-1:0] repl_wdata(input logic [DATA_W-1:0] wd, input logic [1:0] sz);
    logic [DATA_W-1:0] r;
    case (sz)
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  // Select the addressed lane of the read word, then sign- or zero-extend it.
  function automatic logic [DATA_W-1:0] fmt_load(input logic [DATA_W-1:0] rd, input logic [1:0] lo,
                                                 input logic [1:0] sz, input logic uns);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = rd[{lo, 3'b000} +: 8];
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (sz)
      2'b00:   r = {{24{b[7] & ~uns}}, b};
      2'b01:   r = {{16{h[15] & ~uns}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        lo_q, lo_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              we_q, we_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        exc_q, exc_d;

  // Next-state and next-output logic; memory port fields are zero unless an access is in flight.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lo_d        = lo_q;
    size_d      = size_q;
    uns_d       = uns_q;
    we_d        = we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = 4'b0000;
    mem_addr_d  = {ADDR_W{1'b0}};
    mem_wdata_d = {DATA_W{1'b0}};
    rsp_valid_d = 1'b0;
    rdata_d     = {DATA_W{1'b0}};
    exc_d       = EXC_NONE;
    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          lo_d   = i_eff_addr[1:0];
          size_d = i_size;
          uns_d  = i_unsigned;
          we_d   = i_we;
          if (is_misaligned(i_eff_addr[1:0], i_size)) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            exc_d       = EXC_ALIGN;
          end else begin
            state_d     = S_ISSUE;
            mem_en_d    = 1'b1;
            mem_we_d    = i_we;
            mem_be_d    = byte_en(i_eff_addr[1:0], i_size, i_we);
            mem_addr_d  = {i_eff_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = repl_wdata(i_wdata, i_size);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (i_mem_ack) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rdata_d     = we_q ? {DATA_W{1'b0}} : fmt_load(i_mem_rdata, lo_q, size_q, uns_q);
        end else begin
          state_d     = S_WAIT;
          cnt_d       = 8'd0;
          mem_we_d    = mem_we_q;
          mem_be_d    = mem_be_q;
          mem_addr_d  = mem_addr_q;
          mem_wdata_d = mem_wdata_q;
        end
      end
      S_WAIT: begin
        // Ack takes priority over the timeout on the final wait cycle.
        if (i_mem_ack) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rdata_d     = we_q ? {DATA_W{1'b0}} : fmt_load(i_mem_rdata, lo_q, size_q, uns_q);
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          exc_d       = EXC_TIMEOUT;
        end else begin
          cnt_d       = cnt_q + 8'd1;
          mem_we_d    = mem_we_q;
          mem_be_d    = mem_be_q;
          mem_addr_d  = mem_addr_q;
          mem_wdata_d = mem_wdata_q;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      lo_q        <= 2'b00;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rdata_q     <= {DATA_W{1'b0}};
      exc_q       <= EXC_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lo_q        <= lo_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      exc_q       <= exc_d;
    end
  end

  assign o_req_ready = (state_q == S_IDLE);
  assign o_mem_en    = mem_en_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_be    = mem_be_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rdata     = rdata_q;
  assign o_exc       = exc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver pushes expected responses from
// a behavioural model; a monitor pops and compares on every response pulse.
module tb_mem_access_unit;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_eff_addr;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic        i_we;
  logic [31:0] i_wdata;
  logic        o_mem_en;
  logic [3:0]  o_mem_be;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;
  logic        i_mem_ack;
  logic        o_rsp_valid;
  logic [31:0] o_rdata;
  logic [1:0]  o_exc;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_eff_addr(i_eff_addr), .i_size(i_size), .i_unsigned(i_unsigned),
    .i_we(i_we), .i_wdata(i_wdata),
    .o_mem_en(o_mem_en), .o_mem_be(o_mem_be), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
    .o_rsp_valid(o_rsp_valid), .o_rdata(o_rdata), .o_exc(o_exc)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  exc;
    int          cyc;
  } rsp_t;

  rsp_t sb[$];
  int   n_checks = 0;
  int   n_errs = 0;
  int   cyc = 0;
  int   busy_from = 1;
  int   busy_to = 0;
  int   exp_strobes = 0;
  int   seen_strobes = 0;
  bit   chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit model_misaligned(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                             input logic [1:0] sz, input logic u);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (!u && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2'd1) begin
      v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!u && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_be(input logic [31:0] a, input logic [1:0] sz, input logic we);
    if (!we || sz == 2'd2) return 32'd15;
    if (sz == 2'd0) return 32'd1 << (a % 4);
    return 32'd3 << (2 * ((a / 2) % 2));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] sz);
    if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  // Monitor: ready profile, strobe count, and scoreboard compare on each response.
  always @(negedge clk) begin : mon
    rsp_t e;
    if (chk_en) begin
      check("req_ready", {31'd0, o_req_ready}, {31'd0, !(cyc >= busy_from && cyc <= busy_to)});
      if (o_mem_en) seen_strobes++;
      if (o_rsp_valid) begin
        check("rsp_pending", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("rsp_cycle", 32'(cyc), 32'(e.cyc));
          check("rsp_rdata", o_rdata, e.rdata);
          check("rsp_exc", {30'd0, o_exc}, {30'd0, e.exc});
        end
      end
    end
  end

  // w: 0 = ack in ISSUE, k = ack on the k-th WAIT cycle, > TIMEOUT = never acked.
  task automatic do_req(input logic [31:0] a, input logic [1:0] sz, input logic u, input logic we,
                        input logic [31:0] wd, input logic [31:0] rd, input int w, input bit hold);
    int   n;
    bit   ok;
    bit   mis;
    rsp_t e;
    i_req_valid = 1'b1;
    i_eff_addr  = a;
    i_size      = sz;
    i_unsigned  = u;
    i_we        = we;
    i_wdata     = wd;
    i_mem_rdata = rd;
    ok = 1'b0;
    n  = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (o_req_ready) begin
        ok = 1'b1;
        n  = cyc;
        break;
      end
    end
    check("accept_within_budget", {31'd0, ok}, 32'd1);
    if (!ok) begin
      i_req_valid = 1'b0;
      return;
    end
    mis = model_misaligned(a, sz);
    if (mis) begin
      e.exc = 2'b01; e.cyc = n + 1; e.rdata = 32'd0;
    end else if (w > TIMEOUT) begin
      e.exc = 2'b10; e.cyc = n + 2 + TIMEOUT; e.rdata = 32'd0;
    end else begin
      e.exc = 2'b00; e.cyc = n + 2 + w;
      e.rdata = we ? 32'd0 : model_load(rd, a, sz, u);
    end
    @(posedge clk); #1;
    if (!hold) i_req_valid = 1'b0;
    busy_from = n + 1;
    busy_to   = e.cyc;
    sb.push_back(e);
    if (mis) return;
    exp_strobes++;
    i_mem_ack = (w == 0);
    @(negedge clk);
    check("issue_mem_en", {31'd0, o_mem_en}, 32'd1);
    check("issue_mem_we", {31'd0, o_mem_we}, {31'd0, we});
    check("issue_mem_addr", o_mem_addr, a & 32'hFFFF_FFFC);
    check("issue_mem_be", {28'd0, o_mem_be}, model_be(a, sz, we));
    if (we) check("issue_mem_wdata", o_mem_wdata, model_wdata(wd, sz));
    for (int k = 1; k <= w && k <= TIMEOUT; k++) begin
      @(posedge clk); #1;
      i_mem_ack = (k == w);
    end
    @(posedge clk); #1;
    i_mem_ack = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"},     {31'd0, o_req_ready}, 32'd1);
    check({tag, "_mem_en"},    {31'd0, o_mem_en},    32'd0);
    check({tag, "_mem_we"},    {31'd0, o_mem_we},    32'd0);
    check({tag, "_mem_be"},    {28'd0, o_mem_be},    32'd0);
    check({tag, "_mem_addr"},  o_mem_addr,           32'd0);
    check({tag, "_mem_wdata"}, o_mem_wdata,          32'd0);
    check({tag, "_rsp_valid"}, {31'd0, o_rsp_valid}, 32'd0);
    check({tag, "_rdata"},     o_rdata,              32'd0);
    check({tag, "_exc"},       {30'd0, o_exc},       32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, wd, rd;
    logic [1:0]  sz;
    int          r, w, n;
    bit          hold;
    i_reset = 1'b1; i_req_valid = 1'b0; i_eff_addr = 32'd0; i_size = 2'd0;
    i_unsigned = 1'b0; i_we = 1'b0; i_wdata = 32'd0; i_mem_rdata = 32'd0; i_mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    check_quiet("reset");
    chk_en = 1'b1;
    @(posedge clk); #1;

    do_req(32'h0000_1003, 2'd0, 1'b0, 1'b0, 32'd0, 32'h80FF_0102, 0, 1'b0);
    do_req(32'h0000_1003, 2'd0, 1'b1, 1'b0, 32'd0, 32'h80FF_0102, 0, 1'b0);
    do_req(32'h0000_2002, 2'd1, 1'b0, 1'b1, 32'h1234_ABCD, 32'hDEAD_BEEF, 3, 1'b0);
    do_req(32'h0000_3001, 2'd2, 1'b0, 1'b0, 32'd0, 32'h1111_2222, 0, 1'b0);
    do_req(32'h0000_3000, 2'd3, 1'b0, 1'b0, 32'd0, 32'h1111_2222, 0, 1'b0);
    do_req(32'h0000_4000, 2'd2, 1'b0, 1'b0, 32'd0, 32'hCAFE_F00D, TIMEOUT + 1, 1'b0);
    do_req(32'h0000_4000, 2'd2, 1'b0, 1'b0, 32'd0, 32'hCAFE_F00D, TIMEOUT, 1'b0);
    do_req(32'h0000_5002, 2'd1, 1'b0, 1'b0, 32'd0, 32'h8001_7FFF, 1, 1'b0);

    // Reset during WAIT abandons the store; the late ack must not produce a response.
    i_req_valid = 1'b1; i_eff_addr = 32'h0000_0100; i_size = 2'd2; i_we = 1'b1; i_wdata = 32'h5A5A_5A5A;
    n = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (o_req_ready) begin n = cyc; break; end
    end
    check("reset_test_accept", {31'd0, n >= 0}, 32'd1);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    busy_from = n + 1;
    busy_to = n + 4;
    exp_strobes++;
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    i_mem_ack = 1'b1;
    @(negedge clk);
    check_quiet("midwait_reset");
    @(posedge clk); #1;
    i_mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back with valid held high.
    for (int i = 0; i < 6; i++) begin
      a = $urandom & 32'hFFFF_FFFC;
      do_req(a | 32'(i % 4), 2'(i % 3), 1'(i % 2), 1'(i / 3), $urandom, $urandom, i % 2, i != 5);
    end

    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      wd = $urandom;
      rd = $urandom;
      r  = $urandom_range(0, 9);
      w  = (r < 6) ? (r % 4) : ((r < 8) ? TIMEOUT : TIMEOUT + 1);
      hold = (i != 39) && ($urandom_range(0, 1) == 1);
      do_req(a, sz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wd, rd, w, hold);
    end

    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("mem_strobe_count", 32'(seen_strobes), 32'(exp_strobes));
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
